mix_col_iter: RTL and testbench
===============================

MIX_COL_ITER -- requirements
Module: mix_col_iter

Interface
REQ-001 SHALL have parameter COL_PER_CYC, default 1, setting the number of state columns transformed per cycle (legal values 1, 2, 4; any other value is a elaboration error).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, meaning in_data and bypass are valid.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept a state.
REQ-006 SHALL have port in_data, input, 128, the AES state: word w0 in [127:96] through w3 in [31:0]; within each word, byte r0 is in [31:24] through r3 in [7:0].
REQ-007 SHALL have port bypass, input, 1, sampled with in_data; 1 = final-round pass-through with no MixColumns.
REQ-008 SHALL have port out_valid, output, 1, meaning out_data holds a finished result.
REQ-009 SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-010 SHALL have port out_data, output, 128, the result, using the same packing as in_data.

Function
REQ-011 SHALL implement the forward AES MixColumns per column:
- o0=2a0^3a1^a2^a3; o1=a0^2a1^3a2^a3; o2=a0^a1^2a2^3a3; o3=3a0^a1^a2^2a3.
- 2x = xtime: shift left by 1, then XOR 0x1B if bit 7 was set; 3x = 2x^x; all results 8 bits.
REQ-012 SHALL use the FSM states IDLE, BUSY, DONE.
REQ-013 SHALL accept an input when in_valid&&in_ready is high on a clock edge, and on that edge SHALL:
- register in_data and bypass;
- clear the column counter col to 0;
- go to BUSY.
REQ-014 SHALL drive in_ready=1 only in IDLE, so an in_valid in BUSY or DONE is not accepted and the upstream must hold it.
REQ-015 SHALL, in BUSY, transform COL_PER_CYC columns per edge, starting at column index col, writing them in place, and advancing col by COL_PER_CYC.
REQ-016 SHALL go from BUSY to DONE on the edge that processes column 3; col wraps to 0.
REQ-017 SHALL, when bypass is registered as 1, still spend the BUSY cycles but leave the columns unchanged, keeping latency independent of bypass.
REQ-018 SHALL time out_valid from the acceptance edge at T: out_valid rises after edge T+4/COL_PER_CYC (T+4, T+2 or T+1).
REQ-019 SHALL, in DONE, hold out_valid=1 and out_data stable until out_valid&&out_ready on an edge, then go to IDLE with out_valid=0.
REQ-020 SHALL keep in_ready=0 in the DONE-exit cycle; the next acceptance occurs at the earliest on the following edge.
REQ-021 SHALL give a steady-state throughput of one state per 4/COL_PER_CYC+2 cycles when out_ready is held at 1.
REQ-022 SHALL drive out_data as the internal state register in every state, and as zero while out_valid=0 is not required.
REQ-023 SHALL keep each column's output independent of other columns; no cross-column carries.

Reset
REQ-024 SHALL, when rst_n=0 at any time (including mid-BUSY or in DONE), immediately force:
- state=IDLE, col=0;
- internal state register=0, bypass register=0;
- out_valid=0, out_data=0, in_ready=0.
REQ-025 SHALL drive in_ready=1 from the first clock edge after rst_n deasserts; any partially processed state is discarded.

Verification
REQ-026 SHALL check the FIPS-197 columns, COL_PER_CYC=1, bypass=0:
- in_data=db135345_f20a225c_01010101_c6c6c6c6 -> out_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6;
- out_valid first seen 4 edges after acceptance.
REQ-027 SHALL check in_data=d4d4d4d5_2d26314c_00000000_ffffffff -> out_data=d5d5d7d6_4d7ebdf8_00000000_ffffffff for COL_PER_CYC=1, 2 and 4, with latency 4, 2 and 1 respectively.
REQ-028 SHALL check bypass=1 with in_data=db135345_f20a225c_01010101_c6c6c6c6 -> identical out_data, with the same latency as bypass=0.
REQ-029 SHALL check backpressure: out_ready=0 for 10 cycles after out_valid rises gives out_valid held 1, out_data stable and in_ready=0; a second in_valid is only accepted after out_ready=1 plus one edge.
REQ-030 SHALL check reset mid-operation: rst_n pulsed low at the second BUSY cycle gives out_valid=0 and out_data=0 immediately; in_ready=1 after release; a new vector then completes correctly.

Source files
------------

// File: rtl/mix_col_iter.sv
// mix_col_iter: iterative AES MixColumns, COL_PER_CYC columns per cycle, valid/ready in and out
//   clk, rst_n (async active-low)
//   in_valid/in_ready/in_data[127:0]/bypass : state intake, w0 in [127:96], r0 at top of each word
//   out_valid/out_ready/out_data[127:0]     : finished state, same packing
module mix_col_iter #(
  parameter int COL_PER_CYC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  if (COL_PER_CYC != 1 && COL_PER_CYC != 2 && COL_PER_CYC != 4) begin : g_bad_cpc
    $error("mix_col_iter: COL_PER_CYC must be 1, 2 or 4");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [1:0] STEP = 2'(COL_PER_CYC);
  localparam logic [1:0] MSK  = ~2'(COL_PER_CYC - 1);
  localparam logic [1:0] LAST = 2'(4 - COL_PER_CYC);
  state_t       state, state_nxt;
  logic [1:0]   col;
  logic [127:0] st, st_mix;
  logic         byp, armed;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix_word(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
  // col is always a multiple of COL_PER_CYC, so the group being processed is
  // every column whose index matches col in the bits above the group size
  always_comb begin
    st_mix = st;
    for (int c = 0; c < 4; c++)
      if ((2'(c) & MSK) == (col & MSK)) st_mix[127-32*c -: 32] = mix_word(st[127-32*c -: 32]);
  end
  always_comb begin
    state_nxt = state;
    in_ready  = armed && state == IDLE;
    out_valid = state == DONE;
    out_data  = st;
    if (state == IDLE && in_valid && in_ready) state_nxt = BUSY;
    else if (state == BUSY && col == LAST) state_nxt = DONE;
    else if (state == DONE && out_ready) state_nxt = IDLE;
  end
  // armed holds in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      col   <= '0;
      st    <= '0;
      byp   <= 1'b0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      state <= state_nxt;
      if (in_valid && in_ready) begin
        st  <= in_data;
        byp <= bypass;
        col <= '0;
      end else if (state == BUSY) begin
        col <= col + STEP;
        if (!byp) st <= st_mix;
      end
    end
  end
endmodule

// File: tb/tb_mix_col_iter.sv
// tb_mix_col_iter: scoreboard bench driving COL_PER_CYC = 1, 2, 4 instances in lockstep
module tb_mix_col_iter;
  logic         clk = 0, rst_n = 0;
  logic [2:0]   in_valid = '0, in_ready, out_valid;
  logic [127:0] in_data = '0;
  logic         bypass = 0, out_ready = 0, rnd_or = 0;
  logic [127:0] out_data [3];
  int           pass_cnt = 0, chk_cnt = 0, cyc = 0;
  logic [127:0] eq [3][$];
  int           tq [3][$];
  int           last_e [3] = '{default: -100};
  int           acc_t [3];
  logic [2:0]   prev_ov = '0;
  logic [127:0] held [3];
  logic [127:0] mon_exp;
  int           mon_t;
  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] D4_IN    = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] D4_OUT   = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_col_iter #(.COL_PER_CYC(1 << g)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_data(in_data), .bypass(bypass), .out_valid(out_valid[g]),
      .out_ready(out_ready), .out_data(out_data[g])
    );
  end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  // GF(2^8) product by carry-less multiply then reduction modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
    logic [15:0] p = '0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) == 1) p ^= 16'(a) << i;
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011b << (i - 8);
    return p[7:0];
  endfunction
  function automatic logic [127:0] ref_mix(input logic [127:0] d, input logic b);
    logic [127:0] r = d;
    logic [7:0] o;
    int coef [4] = '{2, 3, 1, 1};
    if (b) return d;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        o = '0;
        for (int j = 0; j < 4; j++) o ^= gmul(d[127-32*c-8*j -: 8], coef[(j - row + 4) % 4]);
        r[127-32*c-8*row -: 8] = o;
      end
    return r;
  endfunction
  task automatic send(input logic [127:0] d, input logic b, input logic [127:0] e);
    logic [2:0] acc;
    int n = 0;
    in_data = d;
    bypass = b;
    in_valid = 3'b111;
    for (int k = 0; k < 3; k++) eq[k].push_back(e);
    while (in_valid != 0 && n < 500) begin
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      n++;
      for (int k = 0; k < 3; k++)
        if (acc[k]) begin
          tq[k].push_back(cyc);
          acc_t[k] = cyc;
          chk("accept_after_handshake", 128'(cyc > last_e[k]), 1);
        end
      in_valid &= ~acc;
    end
    if (in_valid != 0) begin
      chk("accept_timeout", in_valid, 0);
      in_valid = 0;
    end
  endtask
  task automatic drain();
    int n = 0;
    while ((eq[0].size() + eq[1].size() + eq[2].size()) != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if ((eq[0].size() + eq[1].size() + eq[2].size()) != 0) begin
      chk_cnt++;
      $display("FAIL drain_timeout: %0d results still pending", eq[0].size() + eq[1].size() + eq[2].size());
    end
  endtask
  task automatic check_reset_outputs();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_out_valid_c%0d", 1 << k), out_valid[k], 0);
      chk($sformatf("rst_out_data_c%0d", 1 << k), out_data[k], 0);
      chk($sformatf("rst_in_ready_c%0d", 1 << k), in_ready[k], 0);
    end
  endtask
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) prev_ov[k] = 0;
      else begin
        if (out_valid[k]) begin
          if (!prev_ov[k]) begin
            if (eq[k].size() == 0 || tq[k].size() == 0) begin
              chk_cnt++;
              $display("FAIL unexpected_output_c%0d: got %h expected no output", 1 << k, out_data[k]);
            end else begin
              mon_exp = eq[k].pop_front();
              mon_t = tq[k].pop_front();
              chk($sformatf("data_c%0d", 1 << k), out_data[k], mon_exp);
              chk($sformatf("latency_c%0d", 1 << k), 128'(cyc - mon_t), 128'(4 >> k));
            end
            held[k] = out_data[k];
          end else chk($sformatf("held_data_c%0d", 1 << k), out_data[k], held[k]);
          chk($sformatf("in_ready_in_done_c%0d", 1 << k), in_ready[k], 0);
          if (out_ready) last_e[k] = cyc + 1;
        end
        prev_ov[k] = out_valid[k];
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_or) out_ready = 1'($urandom_range(0, 1));
  end
  initial begin
    logic [127:0] d;
    logic b;
    int n;
    #3;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", in_ready, 3'b111);
    out_ready = 1;
    send(FIPS_IN, 0, FIPS_OUT);
    send(D4_IN, 0, D4_OUT);
    send(FIPS_IN, 1, FIPS_IN);
    drain();
    out_ready = 0;
    send(D4_IN, 0, D4_OUT);
    d = {$urandom, $urandom, $urandom, $urandom};
    fork
      send(d, 0, ref_mix(d, 0));
      begin
        n = 0;
        while (out_valid != 3'b111 && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk("backpressure_all_valid", out_valid, 3'b111);
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    for (int k = 0; k < 3; k++)
      chk($sformatf("accept_edge_after_release_c%0d", 1 << k), 128'(acc_t[k]), 128'(last_e[k] + 1));
    drain();
    rnd_or = 1;
    repeat (20) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      b = $urandom_range(0, 4) == 0;
      send(d, b, ref_mix(d, b));
    end
    rnd_or = 0;
    out_ready = 1;
    drain();
    send(D4_IN, 0, D4_OUT);
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs();
    for (int k = 0; k < 3; k++) begin
      eq[k].delete();
      tq[k].delete();
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("in_ready_after_mid_reset", in_ready, 3'b111);
    send(D4_IN, 0, D4_OUT);
    drain();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
